// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic, no latency, no flow control; types only.
// Consumers import fetch_pkg::* for the state enum and the IF/ID record.
package fetch_pkg;

    typedef enum logic {
        S_RUN = 1'b0,
        S_END = 1'b1
    } fetch_state_e;

    localparam int                  DEF_IMEM_BYTES = 64;
    localparam int                  WORD_BYTES     = 4;
    localparam int                  INSTR_W        = 32;
    localparam int                  OPCODE_W       = 6;
    localparam logic [INSTR_W-1:0]  NOP_INSTR      = 32'h0000_0000;

    typedef struct packed {
        logic                vld;
        logic [INSTR_W-1:0]  instr;
        logic [31:0]         pc;
        logic [31:0]         pc_plus4;
        logic [OPCODE_W-1:0] next_opcode;
    } ifid_t;

    function automatic logic pc_in_mem(input logic [31:0] addr, input logic [31:0] limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with load / hold / bubble controls.
// Latency: 1 cycle from load to output.
// Backpressure: neither load nor bubble means hold; bubble clears only the valid bit.
module ifid_pipe_reg
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t in_dat,
    output ifid_t out_dat
);

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (load) begin
            ifid_d = in_dat;
        end else if (bubble) begin
            // Payload fields deliberately hold so a bubble does not toggle the decoder inputs
            ifid_d.vld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= '{vld: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0, next_opcode: '0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign out_dat = ifid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register, S_RUN/S_END fetch FSM and IF/ID capture for a combinational instruction memory.
// Latency: word at pc appears in IF/ID one edge later; priority rst > redirect > stall > flush.
// Backpressure: stall holds pc and IF/ID; FETCH_ALIGN_CHECK_EN adds a sticky misalign_fault output.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = DEF_IMEM_BYTES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_target,
    output logic [31:0]         imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    input  logic [OPCODE_W-1:0] imem_lookahead,
    output logic [31:0]         pc,
    output logic                ifid_valid,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [31:0]         ifid_pc,
    output logic [31:0]         ifid_pc_plus4,
    output logic [OPCODE_W-1:0] ifid_next_opcode,
    output logic                fetch_done
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                misalign_fault
`endif
);

    localparam logic [31:0] MEM_LIMIT = 32'(IMEM_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic         ifid_load, ifid_bubble;
    logic         redir_misaligned;
    ifid_t        ifid_in, ifid_out;

    assign pc_plus4 = pc_q + 32'(WORD_BYTES);

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign redir_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign fault_d          = fault_q | redir_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign misalign_fault = fault_q;
`else
    assign redir_misaligned = 1'b0;
`endif

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        fetch_done  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (redirect_valid) begin
                    ifid_bubble = 1'b1;
                    if (!redir_misaligned) begin
                        pc_d    = redirect_target;
                        state_d = pc_in_mem(redirect_target, MEM_LIMIT) ? S_RUN : S_END;
                    end
                end else if (!stall) begin
                    pc_d        = pc_plus4;
                    state_d     = pc_in_mem(pc_plus4, MEM_LIMIT) ? S_RUN : S_END;
                    ifid_load   = !flush;
                    ifid_bubble = flush;
                end
            end
            S_END: begin
                fetch_done  = 1'b1;
                ifid_bubble = 1'b1;
                // Only an in-range, accepted redirect restarts fetching; pc otherwise parks
                if (redirect_valid && !redir_misaligned && pc_in_mem(redirect_target, MEM_LIMIT)) begin
                    pc_d    = redirect_target;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= S_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign ifid_in = '{vld: 1'b1, instr: imem_data, pc: pc_q, pc_plus4: pc_plus4,
                       next_opcode: imem_lookahead};

    ifid_pipe_reg u_ifid_pipe_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .bubble  (ifid_bubble),
        .in_dat  (ifid_in),
        .out_dat (ifid_out)
    );

    assign imem_addr        = pc_q;
    assign pc               = pc_q;
    assign ifid_valid       = ifid_out.vld;
    assign ifid_instr       = ifid_out.instr;
    assign ifid_pc          = ifid_out.pc;
    assign ifid_pc_plus4    = ifid_out.pc_plus4;
    assign ifid_next_opcode = ifid_out.next_opcode;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: 64-byte big-endian memory model, reference PC/FSM model and
// a scoreboard of expected IF/ID captures; directed checks follow the fetch scenarios.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [5:0]  imem_lookahead;
    logic [31:0] pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [5:0]  ifid_next_opcode;
    logic        fetch_done;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .imem_lookahead   (imem_lookahead),
        .pc               (pc),
        .ifid_valid       (ifid_valid),
        .ifid_instr       (ifid_instr),
        .ifid_pc          (ifid_pc),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_next_opcode (ifid_next_opcode),
        .fetch_done       (fetch_done)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_fault   (misalign_fault)
`endif
    );

    logic [7:0] mem [64];

    function automatic logic [7:0] mb(input logic [31:0] a);
        if (a < 32'd64) return mem[a[5:0]];
        return 8'h00;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mb(a), mb(a + 32'd1), mb(a + 32'd2), mb(a + 32'd3)};
    endfunction

    logic [7:0] la_byte;
    always_comb begin
        imem_data      = word_at(imem_addr);
        la_byte        = mb(imem_addr + 32'd4);
        imem_lookahead = la_byte[7:2];
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [5:0]  op;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] mpc;
    logic        mend, mvalid, mfault;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          caps;
    logic [7:0]  tmp_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs();
        check("pc", pc, mpc);
        check("imem_addr", imem_addr, mpc);
        check("fetch_done", 32'(fetch_done), 32'(mend));
        check("ifid_valid", 32'(ifid_valid), 32'(mvalid));
        check("ifid_instr", ifid_instr, cur.instr);
        check("ifid_pc", ifid_pc, cur.pc);
        check("ifid_pc_plus4", ifid_pc_plus4, cur.pc4);
        check("ifid_next_opcode", 32'(ifid_next_opcode), 32'(cur.op));
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign_fault", 32'(misalign_fault), 32'(mfault));
`endif
    endtask

    task automatic do_reset(input logic st, input logic rv, input logic [31:0] rt);
        rst = 1'b1; stall = st; flush = 1'b1; redirect_valid = rv; redirect_target = rt;
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        mpc = 32'h0; mend = 1'b0; mvalid = 1'b0; mfault = 1'b0; cur = '0;
        sb.delete();
        compare_outputs();
    endtask

    task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rt);
        logic cap;
        logic bad;
        cap = 1'b0;
        stall = st; flush = fl; redirect_valid = rv; redirect_target = rt;
`ifdef FETCH_ALIGN_CHECK_EN
        bad = rv && (rt[1:0] != 2'b00);
`else
        bad = 1'b0;
`endif
        if (bad) mfault = 1'b1;
        if (!mend) begin
            if (rv) begin
                mvalid = 1'b0;
                if (!bad) begin
                    mpc  = rt;
                    mend = (rt >= 32'd64);
                end
            end else if (!st) begin
                if (fl) begin
                    mvalid = 1'b0;
                end else begin
                    tmp_b = mb(mpc + 32'd4);
                    sb.push_back('{instr: word_at(mpc), pc: mpc, pc4: mpc + 32'd4, op: tmp_b[7:2]});
                    cap    = 1'b1;
                    mvalid = 1'b1;
                end
                mpc  = mpc + 32'd4;
                mend = (mpc >= 32'd64);
            end
        end else begin
            mvalid = 1'b0;
            if (rv && !bad && rt < 32'd64) begin
                mpc  = rt;
                mend = 1'b0;
            end
        end
        @(posedge clk); #1;
        if (cap) begin
            if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else cur = sb.pop_front();
        end
        compare_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 5);
        mem[0] = 8'h00; mem[1] = 8'h22; mem[2] = 8'h20; mem[3] = 8'h01; mem[4] = 8'h0C;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset overrides a simultaneous stall and redirect
        do_reset(1'b1, 1'b1, 32'd40);
        check("rst_pc", pc, 32'd0);
        check("rst_valid", 32'(ifid_valid), 32'd0);

        step(0, 0, 0, 0);
        check("first_instr", ifid_instr, 32'h0022_2001);
        check("first_op", 32'(ifid_next_opcode), 32'h03);
        check("first_pc4", ifid_pc_plus4, 32'd4);
        check("first_next_pc", pc, 32'd4);

        step(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, (k == 1), 0, 0);
            check("stall_pc", pc, 32'd8);
            check("stall_ifid_pc", ifid_pc, 32'd4);
        end
        step(0, 0, 0, 0);
        check("stall_release_pc", pc, 32'd12);

        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("flush_pc", pc, 32'd20);
        check("flush_valid", 32'(ifid_valid), 32'd0);
        step(1, 0, 1, 32'd28);
        check("redir_pc", pc, 32'd28);
        step(0, 0, 0, 0);
        check("redir_cap_pc", ifid_pc, 32'd28);
        check("redir_cap_valid", 32'(ifid_valid), 32'd1);

        step(0, 0, 1, 32'd0);
        caps = 0;
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 0, 0);
            if (ifid_valid) caps++;
        end
        check("freerun_caps", 32'(caps), 32'd16);
        check("end_pc", pc, 32'd64);
        check("end_done", 32'(fetch_done), 32'd1);
        step(1, 1, 0, 0);
        check("end_bubble", 32'(ifid_valid), 32'd0);
        step(0, 0, 1, 32'd100);
        check("end_oob_redir_pc", pc, 32'd64);
        step(0, 0, 1, 32'd8);
        check("restart_done", 32'(fetch_done), 32'd0);
        step(0, 0, 0, 0);
        check("restart_cap_pc", ifid_pc, 32'd8);

        step(0, 0, 1, 32'd100);
        check("run_oob_done", 32'(fetch_done), 32'd1);
        step(0, 0, 1, 32'd0);
        step(0, 0, 0, 0);

        step(1, 0, 0, 0);
        do_reset(1'b1, 1'b0, 32'd0);

        step(0, 0, 0, 0);
        step(0, 0, 1, 32'd22);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign_pc_hold", pc, 32'd4);
        check("misalign_flag", 32'(misalign_fault), 32'd1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0);
        check("misalign_sticky", 32'(misalign_fault), 32'd1);
        do_reset(1'b0, 1'b0, 32'd0);
        check("misalign_cleared", 32'(misalign_fault), 32'd0);
`else
        check("unaligned_pc", pc, 32'd22);
        for (int k = 0; k < 11; k++) step(0, 0, 0, 0);
        check("unaligned_last_pc", ifid_pc, 32'd62);
        check("unaligned_end", 32'(fetch_done), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
